// File: rtl/png_ctrl_pkg.sv
// Shared definitions for the PNG feed controller: state encoding and
// default sizing of the byte buffer and the stall/drain watchdogs.
package png_ctrl_pkg;

  localparam int NBYTES_DEF    = 69;
  localparam int STALL_MAX_DEF = 256;
  localparam int DRAIN_MAX_DEF = 4096;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

endpackage

// File: rtl/png_feed_ctrl.sv
// Sequencer that loads the PNG byte buffer, starts the decoder, streams the
// buffered bytes into it under iready flow control and then waits for the
// first decoded pixel. Stall and drain watchdogs divert to a sticky error.
module png_feed_ctrl
  import png_ctrl_pkg::*;
#(
  parameter int NBYTES    = NBYTES_DEF,
  parameter int STALL_MAX = STALL_MAX_DEF,
  parameter int DRAIN_MAX = DRAIN_MAX_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        go,
  input  logic                        abort,
  output logic                        load,
  output logic                        shift,
  output logic                        istart,
  output logic                        ivalid,
  input  logic                        iready,
  input  logic                        ovalid,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [$clog2(NBYTES+1)-1:0] byte_cnt
);

  localparam int CW = $clog2(NBYTES + 1);
  localparam int SW = $clog2(STALL_MAX + 1);
  localparam int DW = $clog2(DRAIN_MAX + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            err_q, err_d;

  // Next-state and counter logic; abort overrides everything, including go.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    stall_d    = stall_q;
    drain_d    = drain_q;
    err_d      = err_q;
    if (abort) begin
      state_d = ST_IDLE;
      err_d   = 1'b0;
      stall_d = '0;
      drain_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          state_d = ST_START;
        end
        ST_START: begin
          byte_cnt_d = '0;
          stall_d    = '0;
          state_d    = ST_STREAM;
        end
        ST_STREAM: begin
          if (iready) begin
            stall_d    = '0;
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (byte_cnt_q == CW'(NBYTES - 1)) begin
              drain_d = '0;
              state_d = ST_DRAIN;
            end
          end else if (stall_q == SW'(STALL_MAX - 1)) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (ovalid) begin
            state_d = ST_DONE;
          end else if (drain_q == DW'(DRAIN_MAX - 1)) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        ST_ERR: begin
          if (go) begin
            err_d   = 1'b0;
            state_d = ST_LOAD;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      stall_q    <= '0;
      drain_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      stall_q    <= stall_d;
      drain_q    <= drain_d;
      err_q      <= err_d;
    end
  end

  // Strobes decode from the current state and are masked by abort so that
  // an aborted cycle never loads, starts or moves a byte.
  always_comb begin
    load     = (state_q == ST_LOAD)   && !abort;
    istart   = (state_q == ST_START)  && !abort;
    ivalid   = (state_q == ST_STREAM) && !abort;
    shift    = ivalid && iready;
    busy     = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
    done     = (state_q == ST_DONE);
    err      = err_q;
    byte_cnt = byte_cnt_q;
  end

endmodule

// File: tb/tb_png_feed_ctrl.sv
// Bench for png_feed_ctrl: models the 552-bit byte buffer and the decoder's
// input side, keeps a queue of expected PNG bytes and checks every transfer.
module tb_png_feed_ctrl;
  import png_ctrl_pkg::*;

  localparam int NB = 69;
  localparam int CW = $clog2(NB + 1);
  localparam logic [551:0] PNG_IMAGE = 552'h89504E470D0A1A0A_0000000D49484452_0000000100000001_0802000000907753DE_0000000C49444154_08D763F8CFC00000_0301010018DD8DB0_0000000049454E44_AE426082;

  logic clk = 1'b0;
  logic rst, go, abort, iready, ovalid;
  logic load, shift, istart, ivalid, busy, done, err;
  logic [CW-1:0] byte_cnt;

  int vectors = 0;
  int miscompares = 0;
  int load_cnt = 0, istart_cnt = 0, shift_cnt = 0, done_cnt = 0;
  logic [7:0]   exp_q[$];
  logic [7:0]   exp_b;
  logic [551:0] buf_q = '0;

  png_feed_ctrl #(.NBYTES(NB), .STALL_MAX(256), .DRAIN_MAX(4096)) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .load(load), .shift(shift),
    .istart(istart), .ivalid(ivalid), .iready(iready), .ovalid(ovalid),
    .busy(busy), .done(done), .err(err), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  // Byte buffer and decoder input model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (load) begin
        load_cnt++;
        buf_q = PNG_IMAGE;
      end
      if (istart) istart_cnt++;
      if (done) done_cnt++;
      if (shift) begin
        shift_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL ibyte: got transfer of %h, required no transfer", buf_q[551:544]);
        end else begin
          exp_b = exp_q.pop_front();
          if (buf_q[551:544] !== exp_b) begin
            miscompares++;
            $display("FAIL ibyte: got %h, required %h", buf_q[551:544], exp_b);
          end
        end
        buf_q = buf_q << 8;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_image();
    logic [551:0] img;
    img = PNG_IMAGE;
    for (int i = 0; i < NB; i++) exp_q.push_back(img[551 - 8*i -: 8]);
  endtask

  task automatic clear_counts();
    load_cnt = 0; istart_cnt = 0; shift_cnt = 0; done_cnt = 0;
  endtask

  // go pulse then walk through LOAD and START into the first STREAM cycle
  task automatic start_run();
    push_image();
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    step();
  endtask

  // Drive iready (0: always high, 1: high one cycle in three) until byte_cnt hits target
  task automatic wait_cnt(input int target, input int pattern);
    int k;
    bit hit;
    k = 0;
    hit = 0;
    while (!hit && k < 1000) begin
      iready = (pattern == 0) ? 1'b1 : ((k % 3) == 0);
      step();
      k++;
      if (byte_cnt == CW'(target)) hit = 1;
    end
    if (!hit) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_byte_cnt: got %0d, required %0d within 1000 cycles", byte_cnt, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; abort = 1'b0; iready = 1'b0; ovalid = 1'b0;
    #12;
    vectors++;
    if ({load, shift, istart, ivalid, busy, done, err} !== 7'b0 || byte_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b cnt %0d, required 0000000 cnt 0",
               {load, shift, istart, ivalid, busy, done, err}, byte_cnt);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_nominal();
    clear_counts();
    iready = 1'b1;
    push_image();
    go = 1'b1;
    step();
    go = 1'b0;
    vectors++;
    if ({load, istart, busy} !== 3'b101) begin
      miscompares++;
      $display("FAIL load_cycle1: got load/istart/busy %b, required 101", {load, istart, busy});
    end
    step();
    vectors++;
    if ({load, istart} !== 2'b01) begin
      miscompares++;
      $display("FAIL istart_cycle2: got load/istart %b, required 01", {load, istart});
    end
    step();
    vectors++;
    if ({ivalid, shift} !== 2'b11) begin
      miscompares++;
      $display("FAIL shift_cycle3: got ivalid/shift %b, required 11", {ivalid, shift});
    end
    wait_cnt(NB - 1, 0);
    wait_cnt(NB, 0);
    vectors++;
    if ({ivalid, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL drain_entry: got ivalid/busy %b, required 01", {ivalid, busy});
    end
    repeat (4) step();
    ovalid = 1'b1;
    step();
    ovalid = 1'b0;
    vectors++;
    if ({done, err, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL done_pulse: got done/err/busy %b, required 100", {done, err, busy});
    end
    step();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_one_cycle: got %b, required 0", done);
    end
    vectors++;
    if (shift_cnt != NB || load_cnt != 1 || istart_cnt != 1 || done_cnt != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL nominal_counts: got shifts %0d loads %0d istarts %0d dones %0d left %0d, required 69 1 1 1 0",
               shift_cnt, load_cnt, istart_cnt, done_cnt, exp_q.size());
    end
  endtask

  task automatic test_throttled();
    clear_counts();
    start_run();
    wait_cnt(NB, 1);
    vectors++;
    if (byte_cnt !== CW'(NB) || ivalid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL throttled_drain_entry: got cnt %0d ivalid %b busy %b, required 69 0 1", byte_cnt, ivalid, busy);
    end
    ovalid = 1'b1;
    step();
    ovalid = 1'b0;
    vectors++;
    if (done !== 1'b1 || shift_cnt != NB || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL throttled_result: got done %b shifts %0d left %0d, required 1 69 0", done, shift_cnt, exp_q.size());
    end
    step();
  endtask

  task automatic test_stall_error();
    clear_counts();
    start_run();
    wait_cnt(10, 0);
    iready = 1'b0;
    repeat (255) step();
    vectors++;
    if ({ivalid, err} !== 2'b10 || byte_cnt !== CW'(10)) begin
      miscompares++;
      $display("FAIL stall_255: got ivalid/err %b cnt %0d, required 10 cnt 10", {ivalid, err}, byte_cnt);
    end
    step();
    vectors++;
    if ({err, busy, ivalid} !== 3'b100) begin
      miscompares++;
      $display("FAIL stall_256: got err/busy/ivalid %b, required 100", {err, busy, ivalid});
    end
    exp_q.delete();
    step();
    step();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b, required 1", err);
    end
    clear_counts();
    iready = 1'b1;
    push_image();
    go = 1'b1;
    step();
    go = 1'b0;
    vectors++;
    if ({err, load} !== 2'b01) begin
      miscompares++;
      $display("FAIL err_go_rerun: got err/load %b, required 01", {err, load});
    end
    step();
    step();
    wait_cnt(NB, 0);
    ovalid = 1'b1;
    step();
    ovalid = 1'b0;
    vectors++;
    if ({done, err} !== 2'b10 || shift_cnt != NB) begin
      miscompares++;
      $display("FAIL rerun_done: got done/err %b shifts %0d, required 10 69", {done, err}, shift_cnt);
    end
    step();
  endtask

  task automatic test_drain_timeout();
    start_run();
    wait_cnt(NB, 0);
    repeat (4095) step();
    vectors++;
    if ({err, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL drain_4095: got err/busy %b, required 01", {err, busy});
    end
    step();
    vectors++;
    if ({err, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL drain_4096: got err/busy %b, required 10", {err, busy});
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    vectors++;
    if ({err, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL abort_clears_err: got err/busy %b, required 00", {err, busy});
    end
  endtask

  task automatic test_abort_reset();
    start_run();
    wait_cnt(30, 0);
    abort = 1'b1;
    #1;
    vectors++;
    if ({shift, ivalid} !== 2'b00) begin
      miscompares++;
      $display("FAIL abort_strobes: got shift/ivalid %b, required 00", {shift, ivalid});
    end
    step();
    abort = 1'b0;
    vectors++;
    if ({busy, shift, ivalid} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_idle: got busy/shift/ivalid %b, required 000", {busy, shift, ivalid});
    end
    exp_q.delete();
    go = 1'b1;
    abort = 1'b1;
    step();
    go = 1'b0;
    abort = 1'b0;
    vectors++;
    if ({load, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL abort_over_go: got load/busy %b, required 00", {load, busy});
    end
    start_run();
    wait_cnt(20, 0);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({load, shift, istart, ivalid, busy, done, err} !== 7'b0 || byte_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_stream: got %b cnt %0d, required 0000000 cnt 0",
               {load, shift, istart, ivalid, busy, done, err}, byte_cnt);
    end
    step();
    step();
    vectors++;
    if (shift !== 1'b0) begin
      miscompares++;
      $display("FAIL shift_in_reset: got %b, required 0", shift);
    end
    rst = 1'b0;
    exp_q.delete();
    step();
  endtask

  task automatic test_go_ignored();
    clear_counts();
    start_run();
    wait_cnt(40, 0);
    go = 1'b1;
    step();
    go = 1'b0;
    wait_cnt(NB, 0);
    go = 1'b1;
    step();
    go = 1'b0;
    ovalid = 1'b1;
    step();
    ovalid = 1'b0;
    vectors++;
    if (done !== 1'b1 || load_cnt != 1 || istart_cnt != 1 || shift_cnt != NB || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL go_ignored: got done %b loads %0d istarts %0d shifts %0d left %0d, required 1 1 1 69 0",
               done, load_cnt, istart_cnt, shift_cnt, exp_q.size());
    end
    step();
    vectors++;
    if ({busy, load} !== 2'b00) begin
      miscompares++;
      $display("FAIL go_ignored_idle: got busy/load %b, required 00", {busy, load});
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_throttled();
    test_stall_error();
    test_drain_timeout();
    test_abort_reset();
    test_go_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got run still active at time limit, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/png_feed_ctrl.md
PNG_FEED_CTRL -- requirements
Module: png_feed_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 69, giving the number of PNG bytes held in the byte buffer (552 bits / 8).
REQ-002 SHALL have parameter STALL_MAX, default 256, giving the maximum consecutive cycles with iready low during streaming.
REQ-003 SHALL have parameter DRAIN_MAX, default 4096, giving the maximum cycles from last byte accepted to first ovalid.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-006 SHALL have port go, input, 1, a one-cycle request to decode the buffered image.
REQ-007 SHALL have port abort, input, 1, a synchronous return to IDLE.
REQ-008 SHALL have port load, output, 1, the parallel-load strobe to the byte buffer.
REQ-009 SHALL have port shift, output, 1, the advance-one-byte strobe to the byte buffer.
REQ-010 SHALL have port istart, output, 1, the decoder start pulse.
REQ-011 SHALL have port ivalid, output, 1, the decoder input byte valid.
REQ-012 SHALL have port iready, input, 1, the decoder input ready.
REQ-013 SHALL have port ovalid, input, 1, the decoder pixel valid.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE, DONE or ERR.
REQ-015 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-016 SHALL have port err, output, 1, a sticky error flag.
REQ-017 SHALL have port byte_cnt, output, clog2(NBYTES+1), the count of bytes accepted by the decoder.

Function
REQ-018 SHALL implement states IDLE, LOAD, START, STREAM, DRAIN, DONE and ERR.
REQ-019 In IDLE, go SHALL move to LOAD; go in any other state except ERR SHALL be ignored.
REQ-020 In LOAD, load SHALL be 1 for exactly one cycle, then the state SHALL move to START.
REQ-021 In START, istart SHALL be 1 for exactly one cycle, byte_cnt SHALL clear to 0, and the state SHALL move to STREAM.
REQ-022 The byte buffer presents byte 0 (MSB byte, 8'h89) on data_out after load, and each shift cycle advances it by one byte at the next edge.
REQ-023 In STREAM, ivalid SHALL be 1 combinationally, and shift SHALL equal ivalid & iready, so a byte transfers and the buffer advances on the same edge.
REQ-024 On each STREAM transfer, byte_cnt SHALL increment; a transfer with byte_cnt==NBYTES-1 SHALL move to DRAIN with byte_cnt==NBYTES.
REQ-025 shift and ivalid SHALL be 0 outside STREAM, so no more than NBYTES shifts occur per run.
REQ-026 In STREAM, a stall counter SHALL increment on each iready=0 cycle and clear on iready=1; reaching STALL_MAX SHALL move to ERR.
REQ-027 In DRAIN, a cycle counter SHALL run from 0; ovalid=1 SHALL move to DONE.
REQ-028 In DRAIN, reaching DRAIN_MAX cycles without ovalid SHALL move to ERR; if both occur in the same cycle, ovalid SHALL win.
REQ-029 ovalid SHALL be ignored outside DRAIN.
REQ-030 DONE SHALL last one cycle with done=1, then move to IDLE.
REQ-031 Entry to ERR SHALL set err=1, which SHALL hold until go or abort.
REQ-032 In ERR, go SHALL clear err and move to LOAD in the same cycle.
REQ-033 abort SHALL force IDLE on the next edge from any state, clear err, and deassert load, shift, istart and ivalid that cycle.
REQ-034 abort SHALL take priority over go.
REQ-035 Latency from go to istart SHALL be 2 cycles, and from go to the first possible shift SHALL be 3 cycles.

Reset
REQ-036 rst=1 SHALL asynchronously force IDLE and set load, shift, istart, ivalid, busy, done and err to 0, byte_cnt to 0, and the stall and drain counters to 0.
REQ-037 Reset mid-STREAM SHALL abandon the run; no shift SHALL be issued while rst=1.

Structure
REQ-038 Package png_ctrl_pkg SHALL hold the state enum and the default values of NBYTES, STALL_MAX and DRAIN_MAX.
REQ-039 The module SHALL be a single flat FSM with counters; no sub-module is required.

Verification
REQ-040 The bench SHALL couple this block to the 552-bit byte buffer and the PNG decoder, loaded with the 1x1 RGB test PNG (89504E47...AE426082).
REQ-041 Scenario 1: go with iready held at 1 -> load at cycle 1, istart at cycle 2, exactly 69 shifts, decoder ibyte sequence 89,50,4E,...,82, then ovalid, then one done pulse with err=0.
REQ-042 Scenario 2: iready toggling 1-of-3 cycles -> still exactly 69 transfers, byte order preserved, and byte_cnt==69 at DRAIN entry.
REQ-043 Scenario 3: iready held at 0 for 256 cycles mid-stream -> ERR and err=1; a following go -> a clean rerun ending in done.
REQ-044 Scenario 4: decoder with ovalid suppressed -> ERR exactly 4096 cycles after the 69th transfer.
REQ-045 Scenario 5: abort at byte_cnt==30 -> IDLE next cycle with shift=0; rst asserted mid-STREAM -> all outputs 0 immediately.
REQ-046 Scenario 6: go pulses during STREAM and DRAIN -> ignored, with no extra load or istart issued.
